div: RTL and testbench

- Sequential signed integer divider: the inverse operation to the team's shift-add multiplier.
- Restoring division, one quotient bit per clock, on operand magnitudes; signs are applied in a final fix-up cycle.
- Same start/done/busy handshake style as the multiplier, so both share one arithmetic-unit controller.
- Quotient truncates toward zero. Remainder takes the sign of the dividend.

---
 rtl/div_if.sv | 25 ++
 rtl/div.sv | 141 ++++++++++++++
 tb/tb_div.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and operand/result bundle shared by the divider and its requester.
interface div_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_zero_o;
    logic             done;
    logic             busy;

    // Requester side: issues operations, consumes results.
    modport master (
        output start, dividend_i, divisor_i,
        input  quotient_o, remainder_o, div_zero_o, done, busy
    );

    // Divider side.
    modport slave (
        input  start, dividend_i, divisor_i,
        output quotient_o, remainder_o, div_zero_o, done, busy
    );
endinterface

// File: rtl/div.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, signs applied in a final fix-up cycle. Quotient truncates toward
// zero, remainder follows the dividend's sign. Divide by zero takes a one-cycle
// fast path and reports quotient=-1, remainder=dividend, div_zero_o=1.
module div #(
    parameter int unsigned WIDTH = 16
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;          // quotient shift reg; raw dividend on div-by-zero
    logic [WIDTH-1:0] d_q, d_d;          // divisor magnitude
    logic [WIDTH:0]   r_q, r_d;          // partial remainder
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   shifted, trial;

    // Magnitudes fit in WIDTH unsigned bits, so |MIN| needs no special case.
    assign dvd_abs = bus.dividend_i[WIDTH-1] ? -bus.dividend_i : bus.dividend_i;
    assign dvs_abs = bus.divisor_i[WIDTH-1]  ? -bus.divisor_i  : bus.divisor_i;

    // r < d <= 2^(WIDTH-1) keeps shifted below 2^WIDTH, so trial's MSB is its sign.
    assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_q};

    // Next-state and datapath updates for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        dz_pend_d   = dz_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    busy_d     = 1'b1;
                    r_d        = '0;
                    cnt_d      = '0;
                    sign_quo_d = bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1];
                    sign_rem_d = bus.dividend_i[WIDTH-1];
                    if (bus.divisor_i == '0) begin
                        dz_pend_d = 1'b1;
                        q_d       = bus.dividend_i;
                        state_d   = StFix;
                    end else begin
                        dz_pend_d = 1'b0;
                        q_d       = dvd_abs;
                        d_d       = dvs_abs;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                r_d   = trial[WIDTH] ? shifted : trial;
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dz_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = q_q;
                    div_zero_d  = 1'b1;
                end else begin
                    quotient_d  = sign_quo_q ? -q_q : q_q;
                    remainder_d = sign_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    div_zero_d  = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            dz_pend_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            dz_pend_q   <= dz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.quotient_o  = quotient_q;
    assign bus.remainder_o = remainder_q;
    assign bus.div_zero_o  = div_zero_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_div.sv
// Directed bench for the sequential signed divider (WIDTH=16).
module tb_div;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    div_if #(.WIDTH(16)) bus ();

    div #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request for one edge, then scramble the operands.
    task automatic launch(input logic signed [15:0] a, input logic signed [15:0] b);
        bus.start      = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.dividend_i = 16'($urandom);
        bus.divisor_i  = 16'($urandom);
    endtask

    // Wait (bounded) for done, checking latency, busy profile and results.
    // With inject set, a second request (50/5) is pulsed at cycle 5.
    task automatic finish_op(input string tag, input int exp_lat,
                             input logic signed [15:0] eq, input logic signed [15:0] er,
                             input logic edz, input bit inject);
        int   n = 0;
        logic busy_drop = 1'b0;
        check({tag, " busy_after_accept"}, 16'(bus.busy), 16'd1);
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (inject && n == 4) begin
                bus.start      = 1'b1;
                bus.dividend_i = 16'sd50;
                bus.divisor_i  = 16'sd5;
            end else if (inject && n == 5) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
            if (!bus.busy) busy_drop = 1'b1;
        end
        check({tag, " latency"}, 16'(n), 16'(exp_lat));
        check({tag, " busy_held"}, 16'(busy_drop), 16'd0);
        check({tag, " busy_at_done"}, 16'(bus.busy), 16'd0);
        check({tag, " quotient"}, bus.quotient_o, eq);
        check({tag, " remainder"}, bus.remainder_o, er);
        check({tag, " div_zero"}, 16'(bus.div_zero_o), 16'(edz));
    endtask

    // One further edge: done must have dropped and results must be held.
    task automatic after_done(input string tag, input logic signed [15:0] eq,
                              input logic signed [15:0] er);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 16'(bus.done), 16'd0);
        check({tag, " quotient_held"}, bus.quotient_o, eq);
        check({tag, " remainder_held"}, bus.remainder_o, er);
    endtask

    initial begin
        int   seen_done;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        #2;
        check("rst quotient", bus.quotient_o, 16'h0000);
        check("rst remainder", bus.remainder_o, 16'h0000);
        check("rst div_zero", 16'(bus.div_zero_o), 16'd0);
        check("rst done", 16'(bus.done), 16'd0);
        check("rst busy", 16'(bus.busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(16'sd100, 16'sd7);
        finish_op("100/7", 17, 16'sd14, 16'sd2, 1'b0, 1'b0);
        after_done("100/7", 16'sd14, 16'sd2);

        launch(-16'sd100, 16'sd7);
        finish_op("-100/7", 17, -16'sd14, -16'sd2, 1'b0, 1'b0);
        launch(16'sd100, -16'sd7);
        finish_op("100/-7", 17, -16'sd14, 16'sd2, 1'b0, 1'b0);
        launch(-16'sd100, -16'sd7);
        finish_op("-100/-7", 17, 16'sd14, -16'sd2, 1'b0, 1'b0);
        launch(16'sd5, 16'sd9);
        finish_op("5/9", 17, 16'sd0, 16'sd5, 1'b0, 1'b0);
        launch(16'sh8000, -16'sd1);
        finish_op("min/-1", 17, 16'sh8000, 16'sd0, 1'b0, 1'b0);
        launch(16'sd32767, 16'sd1);
        finish_op("max/1", 17, 16'sd32767, 16'sd0, 1'b0, 1'b0);

        launch(-16'sd1234, 16'sd0);
        finish_op("dz", 1, 16'shFFFF, -16'sd1234, 1'b1, 1'b0);
        after_done("dz", 16'shFFFF, -16'sd1234);
        check("dz div_zero_held", 16'(bus.div_zero_o), 16'd1);

        launch(16'sd7, 16'sd2);
        finish_op("7/2 clears dz", 17, 16'sd3, 16'sd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        launch(16'sd1000, -16'sd3);
        finish_op("ignored start", 17, -16'sd333, 16'sd1, 1'b0, 1'b1);
        after_done("ignored start", -16'sd333, 16'sd1);

        // Second request issued in the done cycle.
        launch(16'sd100, 16'sd7);
        finish_op("b2b first", 17, 16'sd14, 16'sd2, 1'b0, 1'b0);
        launch(-16'sd9, 16'sd4);
        check("b2b done_drop", 16'(bus.done), 16'd0);
        finish_op("b2b second", 17, -16'sd2, -16'sd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset during cycle 8 of an operation.
        launch(16'sd30000, 16'sd7);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst quotient", bus.quotient_o, 16'h0000);
        check("midrst remainder", bus.remainder_o, 16'h0000);
        check("midrst busy", 16'(bus.busy), 16'd0);
        check("midrst done", 16'(bus.done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        check("midrst no_done", 16'(seen_done), 16'd0);
        launch(16'sd30000, 16'sd7);
        finish_op("post-rst 30000/7", 17, 16'sd4285, 16'sd5, 1'b0, 1'b0);
        after_done("post-rst", 16'sd4285, 16'sd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
